// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI memory-side responder: FSM state encoding,
// bus mode constants and the default synchronizer depth.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spiState_t;

    // SCLK idle level; also the reset value of the SCLK synchronizer.
    localparam bit SPI_CPOL = 1'b1;

    // Value shifted into the transmit register behind the data, and the MISO idle level.
    localparam logic SPI_FILL_BIT = 1'b1;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_mem_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_sync / spi_sync_edge
// spi_sync: STAGES-deep flop chain bringing an asynchronous pin into iCLK,
//   reset to RST_VAL.
//   iCLK, iRST : clock, synchronous active-high reset
//   iD         : asynchronous input pin
//   oQ         : synchronized level
// spi_sync_edge: spi_sync plus a further registered copy used for edge
//   detection; strobes are registered one-cycle pulses.
//   oLevel       : synchronized level
//   oRise, oFall : edge strobes, STAGES+1 cycles after the pin edge
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iD,
    output logic oQ
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], iD};
        end
    end

    assign oQ = chain[STAGES-1];

endmodule

module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iD,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    logic levelQ;
    logic prevQ;

    spi_sync #(
        .STAGES  (STAGES),
        .RST_VAL (RST_VAL)
    ) uSync (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iD),
        .oQ   (levelQ)
    );

    // Edge register resets to the same value as the chain, so reset itself never makes a strobe.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            prevQ <= RST_VAL;
            oRise <= 1'b0;
            oFall <= 1'b0;
        end else begin
            prevQ <= levelQ;
            oRise <= levelQ & ~prevQ;
            oFall <= ~levelQ & prevQ;
        end
    end

    assign oLevel = levelQ;

endmodule

// File: rtl/spi_mem_slave.sv
// -----------------------------------------------------------------------------
// spi_mem_slave
// SPI responder (SCLK idles high, MSB first) oversampling the master's lines
// on iCLK. Exchanges one NBIT word per frame: iTXdata is captured at frame
// start and returned on oMISO while the MOSI word is assembled.
//   iCLK, iRST          : system clock, synchronous active-high reset
//   iSCLK, iSS, iMOSI   : SPI pins from the master (SS active low)
//   oMISO               : serial data to the master
//   iTXdata             : word to return, captured on SS fall
//   oRXdata             : last complete received word
//   oRXvalid            : one-cycle pulse when oRXdata updates
//   oFRAMEerr           : one-cycle pulse when a frame aborts early
//   oBUSY               : high while a frame is active (SHIFT or DONE)
// -----------------------------------------------------------------------------
module spi_mem_slave
    import spi_pkg::*;
#(
    parameter int unsigned NBIT        = 128,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSCLK,
    input  logic            iSS,
    input  logic            iMOSI,
    output logic            oMISO,
    input  logic [NBIT-1:0] iTXdata,
    output logic [NBIT-1:0] oRXdata,
    output logic            oRXvalid,
    output logic            oFRAMEerr,
    output logic            oBUSY
);

    localparam int unsigned CNT_W = $clog2(NBIT + 1);

    logic sclkRise;
    logic sclkFall;
    logic unusedSclkLevel;
    logic ssLevel;
    logic ssFall;
    logic unusedSsRise;
    logic mosiS;

    spiState_t        state;
    spiState_t        stateNext;
    logic [NBIT-1:0]  txSr;
    logic [NBIT-1:0]  rxSr;
    logic [CNT_W-1:0] bitCnt;

    logic lastBit_c;
    logic loadTx_c;
    logic shiftTx_c;
    logic shiftRx_c;
    logic rxValid_c;
    logic frameErr_c;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SPI_CPOL)
    ) uSclkSync (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iD     (iSCLK),
        .oLevel (unusedSclkLevel),
        .oRise  (sclkRise),
        .oFall  (sclkFall)
    );

    // SS chain resets low: a frame already running at reset cannot produce a fall.
    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) uSsSync (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iD     (iSS),
        .oLevel (ssLevel),
        .oRise  (unusedSsRise),
        .oFall  (ssFall)
    );

    // Same depth as SCLK so sampled data lines up with the rise strobe.
    spi_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) uMosiSync (
        .iCLK (iCLK),
        .iRST (iRST),
        .iD   (iMOSI),
        .oQ   (mosiS)
    );

    assign lastBit_c = (bitCnt == CNT_W'(NBIT - 1));

    // State register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state; the completing rise wins over a simultaneous SS deassert.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (ssFall) stateNext = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclkRise && lastBit_c) stateNext = ST_DONE;
                else if (ssLevel)          stateNext = ST_IDLE;
            end
            ST_DONE: begin
                if (ssLevel) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Datapath controls per state.
    always_comb begin
        loadTx_c   = 1'b0;
        shiftTx_c  = 1'b0;
        shiftRx_c  = 1'b0;
        rxValid_c  = 1'b0;
        frameErr_c = 1'b0;
        case (state)
            ST_IDLE: begin
                loadTx_c = ssFall;
            end
            ST_SHIFT: begin
                shiftTx_c  = sclkFall;
                shiftRx_c  = sclkRise;
                rxValid_c  = sclkRise && lastBit_c;
                frameErr_c = ssLevel && !(sclkRise && lastBit_c);
            end
            default: ;
        endcase
    end

    // Shift registers and registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            txSr      <= '0;
            rxSr      <= '0;
            bitCnt    <= '0;
            oMISO     <= 1'b1;
            oRXdata   <= '0;
            oRXvalid  <= 1'b0;
            oFRAMEerr <= 1'b0;
            oBUSY     <= 1'b0;
        end else begin
            oRXvalid  <= rxValid_c;
            oFRAMEerr <= frameErr_c;
            oBUSY     <= (stateNext != ST_IDLE);

            if (loadTx_c) begin
                txSr   <= iTXdata;
                bitCnt <= '0;
            end

            if (shiftTx_c) begin
                oMISO <= txSr[NBIT-1];
                txSr  <= {txSr[NBIT-2:0], SPI_FILL_BIT};
            end else if (state != ST_SHIFT) begin
                oMISO <= SPI_FILL_BIT;
            end

            if (shiftRx_c) begin
                rxSr   <= {rxSr[NBIT-2:0], mosiS};
                bitCnt <= bitCnt + CNT_W'(1);
            end

            if (rxValid_c) begin
                oRXdata <= {rxSr[NBIT-2:0], mosiS};
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_slave
// Drives an 8-bit and a 128-bit responder from a behavioural SPI master and
// checks received words, pulses, MISO bits and busy against a word-level model.
// -----------------------------------------------------------------------------
module tb_spi_mem_slave;

    localparam int unsigned SYNC = 2;
    localparam int unsigned LAT  = SYNC + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst8, sclk8, ss8, mosi8, miso8, valid8, err8, busy8;
    logic [7:0]   tx8, rx8;
    logic         rst128, sclk128, ss128, mosi128, miso128, valid128, err128, busy128;
    logic [127:0] tx128, rx128;

    spi_mem_slave #(.NBIT(8), .SYNC_STAGES(SYNC)) dut8 (
        .iCLK(clk), .iRST(rst8), .iSCLK(sclk8), .iSS(ss8), .iMOSI(mosi8),
        .oMISO(miso8), .iTXdata(tx8), .oRXdata(rx8), .oRXvalid(valid8),
        .oFRAMEerr(err8), .oBUSY(busy8)
    );

    spi_mem_slave #(.NBIT(128), .SYNC_STAGES(SYNC)) dut128 (
        .iCLK(clk), .iRST(rst128), .iSCLK(sclk128), .iSS(ss128), .iMOSI(mosi128),
        .oMISO(miso128), .iTXdata(tx128), .oRXdata(rx128), .oRXvalid(valid128),
        .oFRAMEerr(err128), .oBUSY(busy128)
    );

    int nTests = 0;
    int nFail  = 0;
    logic chkEn = 1'b0;

    // Model state written by the master side.
    logic [127:0] words8 [16];
    logic [127:0] words128 [4];
    int push8 = 0, push128 = 0;
    int errExp8 = 0, errExp128 = 0;
    int rise8Cyc = 0, rise128Cyc = 0;

    // Model state written by the compare process.
    int pop8 = 0, pop128 = 0;
    int errSeen8 = 0, errSeen128 = 0;
    logic [127:0] expRx8 = '0, expRx128 = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic misoOf(input int which);
        return (which == 0) ? miso8 : miso128;
    endfunction

    function automatic logic busyOf(input int which);
        return (which == 0) ? busy8 : busy128;
    endfunction

    task automatic setPins(input int which, input logic sck, input logic ss, input logic mosi);
        if (which == 0) begin
            sclk8 = sck; ss8 = ss; mosi8 = mosi;
        end else begin
            sclk128 = sck; ss128 = ss; mosi128 = mosi;
        end
    endtask

    task automatic setTx(input int which, input logic [127:0] v);
        if (which == 0) tx8 = v[7:0];
        else            tx128 = v;
    endtask

    // Every-cycle compare: pulses must match model events, held data must not move.
    always begin
        @(posedge clk);
        #1;
        if (chkEn) begin
            if (rst8) expRx8 = '0;
            if (valid8 === 1'b1) begin
                check("valid8 expected", 128'(pop8 < push8), 128'(1));
                if (pop8 < push8) begin
                    expRx8 = words8[pop8];
                    pop8++;
                    check("valid8 latency", 128'(cyc - rise8Cyc), 128'(LAT));
                end
            end else begin
                check("valid8 low", 128'(valid8), 128'(0));
            end
            if (err8 === 1'b1) begin
                check("err8 expected", 128'(errSeen8 < errExp8), 128'(1));
                errSeen8++;
            end else begin
                check("err8 low", 128'(err8), 128'(0));
            end
            check("rx8 data", 128'(rx8), expRx8);

            if (rst128) expRx128 = '0;
            if (valid128 === 1'b1) begin
                check("valid128 expected", 128'(pop128 < push128), 128'(1));
                if (pop128 < push128) begin
                    expRx128 = words128[pop128];
                    pop128++;
                    check("valid128 latency", 128'(cyc - rise128Cyc), 128'(LAT));
                end
            end else begin
                check("valid128 low", 128'(valid128), 128'(0));
            end
            if (err128 === 1'b1) begin
                check("err128 expected", 128'(errSeen128 < errExp128), 128'(1));
                errSeen128++;
            end else begin
                check("err128 low", 128'(err128), 128'(0));
            end
            check("rx128 data", rx128, expRx128);
        end
    end

    // One master frame: nSend bits from bits[127] downward; optional iTXdata change before bit chgBit.
    task automatic doFrame(input int which, input int nSend, input int half,
                           input logic [127:0] bits, input logic [127:0] txNew,
                           input int chgBit, output logic [127:0] misoGot);
        int n;
        logic [127:0] txCap;
        logic [127:0] word;
        logic expBit;
        n = (which == 0) ? 8 : 128;
        txCap = (which == 0) ? 128'(tx8) : tx128;
        misoGot = '0;
        setPins(which, 1'b1, 1'b0, 1'b0);
        repeat (half) @(negedge clk);
        for (int i = 0; i < nSend; i++) begin
            if (i == chgBit) setTx(which, txNew);
            setPins(which, 1'b0, 1'b0, bits[127-i]);
            repeat (half) @(negedge clk);
            check("busy in frame", 128'(busyOf(which)), 128'(1));
            misoGot[127-i] = misoOf(which);
            expBit = (i < n) ? txCap[n-1-i] : 1'b1;
            check("miso bit", 128'(misoGot[127-i]), 128'(expBit));
            if (i == n - 1) begin
                word = bits >> (128 - n);
                if (which == 0) begin
                    words8[push8] = word; push8++; rise8Cyc = cyc;
                end else begin
                    words128[push128] = word; push128++; rise128Cyc = cyc;
                end
            end
            setPins(which, 1'b1, 1'b0, bits[127-i]);
            repeat (half) @(negedge clk);
        end
        setPins(which, 1'b1, 1'b1, 1'b0);
        if (nSend < n) begin
            if (which == 0) errExp8++;
            else            errExp128++;
        end
        repeat (3 * half) @(negedge clk);
        check("busy after frame", 128'(busyOf(which)), 128'(0));
        check("miso idle", 128'(misoOf(which)), 128'(1));
    endtask

    localparam logic [127:0] W128 = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        logic [127:0] m;
        rst8 = 1'b1; rst128 = 1'b1;
        setPins(0, 1'b1, 1'b1, 1'b0);
        setPins(1, 1'b1, 1'b1, 1'b0);
        tx8 = '0; tx128 = '0;
        repeat (3) @(negedge clk);
        check("reset miso8", 128'(miso8), 128'(1));
        check("reset rx8", 128'(rx8), 128'(0));
        check("reset valid8", 128'(valid8), 128'(0));
        check("reset err8", 128'(err8), 128'(0));
        check("reset busy8", 128'(busy8), 128'(0));
        check("reset miso128", 128'(miso128), 128'(1));
        check("reset rx128", rx128, 128'(0));
        check("reset busy128", 128'(busy128), 128'(0));
        rst8 = 1'b0; rst128 = 1'b0;
        chkEn = 1'b1;
        repeat (10) @(negedge clk);

        // Full frame.
        tx8 = 8'hA5;
        doFrame(0, 8, 8, {8'h3C, 120'h0}, 128'h0, -1, m);
        check("A miso word", 128'(m[127:120]), 128'(8'hA5));
        check("A rx", 128'(rx8), 128'(8'h3C));

        // Back-to-back with iTXdata moving mid-frame.
        tx8 = 8'hFF;
        doFrame(0, 8, 8, {8'h00, 120'h0}, 128'h00, 3, m);
        check("B1 miso word", 128'(m[127:120]), 128'(8'hFF));
        check("B1 rx", 128'(rx8), 128'(8'h00));
        doFrame(0, 8, 8, {8'hFF, 120'h0}, 128'h5A, 3, m);
        check("B2 miso word", 128'(m[127:120]), 128'(8'h00));
        check("B2 rx", 128'(rx8), 128'(8'hFF));

        // Abort after 5 bits: error pulse, data held.
        doFrame(0, 5, 8, {8'b1011_0000, 120'h0}, 128'h5A, -1, m);
        check("abort miso bits", 128'(m[127:123]), 128'(5'b01011));
        check("abort rx held", 128'(rx8), 128'(8'hFF));
        check("abort err count", 128'(errSeen8), 128'(1));

        // Over-clocking: 10 SCLK periods, only the first 8 count.
        tx8 = 8'h96;
        doFrame(0, 10, 8, {8'hC3, 2'b01, 118'h0}, 128'h0, -1, m);
        check("over miso bits", 128'(m[127:118]), 128'({8'h96, 2'b11}));
        check("over rx", 128'(rx8), 128'(8'hC3));

        // Reset during bit 3, SS held low through release.
        tx8 = 8'h5A;
        setPins(0, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            setPins(0, 1'b0, 1'b0, 1'(i & 1));
            if (i == 3) begin
                repeat (3) @(negedge clk);
                rst8 = 1'b1;
                @(negedge clk);
                rst8 = 1'b0;
                check("midrst rx", 128'(rx8), 128'(0));
                check("midrst miso", 128'(miso8), 128'(1));
                check("midrst busy", 128'(busy8), 128'(0));
                repeat (4) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            if (i >= 3) check("midrst busy held", 128'(busy8), 128'(0));
            setPins(0, 1'b1, 1'b0, 1'(i & 1));
            repeat (8) @(negedge clk);
        end
        setPins(0, 1'b1, 1'b1, 1'b0);
        repeat (24) @(negedge clk);
        check("midrst busy after", 128'(busy8), 128'(0));

        // Recovery frame after the reset.
        tx8 = 8'h81;
        doFrame(0, 8, 8, {8'h7E, 120'h0}, 128'h0, -1, m);
        check("R miso word", 128'(m[127:120]), 128'(8'h81));
        check("R rx", 128'(rx8), 128'(8'h7E));

        // 128-bit exchange at the minimum half-period.
        tx128 = W128;
        doFrame(1, 128, 6, W128, 128'h0, -1, m);
        check("W128 miso word", m, W128);
        check("W128 rx", rx128, W128);

        repeat (10) @(negedge clk);
        check("valid8 all seen", 128'(pop8), 128'(push8));
        check("valid8 total", 128'(pop8), 128'(5));
        check("err8 all seen", 128'(errSeen8), 128'(errExp8));
        check("valid128 all seen", 128'(pop128), 128'(push128));
        check("err128 none", 128'(errSeen128), 128'(0));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/spi_mem_slave.md
# spi_mem_slave

SPI responder that sits at the memory end of the serial link driven by the cache controller's SPI master. It receives one NBIT-bit word per frame and simultaneously returns one NBIT-bit word on MISO, MSB first, in the same mode the master uses. The master's clock, select and data lines are oversampled by the local system clock. The block hands each received word to the memory-side logic with a one-cycle valid pulse.

## Interface
- NBIT, 128: bits per frame; must match the master's word width.
- SYNC_STAGES, 2: synchronizer depth on iSCLK/iSS/iMOSI; minimum 2.
- iCLK  input  1  system clock; all logic is on its rising edge.
- iRST  input  1  reset, synchronous and active-high.
- iSCLK  input  1  SPI clock from master; idles high.
- iSS  input  1  slave select; active low.
- iMOSI  input  1  serial data from master.
- oMISO  output  1  serial data to master.
- iTXdata  input  NBIT  word to return; captured at frame start.
- oRXdata  output  NBIT  last complete received word; held until the next complete frame.
- oRXvalid  output  1  one-cycle pulse when oRXdata updates.
- oFRAMEerr  output  1  one-cycle pulse when a frame aborts before NBIT bits.
- oBUSY  output  1  high from frame start until return to IDLE.

## Operation
- Mode: SCLK idles high, MSB first. Data is driven on SCLK falling edges and sampled on SCLK rising edges. The first edge of a frame is a fall.
- Synchronization and edge detection:
  - iSCLK, iSS and iMOSI pass through SYNC_STAGES flops of equal depth.
  - Edges are detected against a further registered copy, giving sclk_rise, sclk_fall and ss_fall as one-cycle strobes.
- IDLE (reset state):
  - oMISO=1, oBUSY=0.
  - On ss_fall: tx_sr <= iTXdata, bit_cnt <= 0, move to SHIFT.
- SHIFT:
  - oBUSY=1.
  - On sclk_fall: oMISO <= tx_sr[NBIT-1], then tx_sr <= {tx_sr[NBIT-2:0],1'b1}.
  - On sclk_rise: rx_sr <= {rx_sr[NBIT-2:0],mosi_s}, bit_cnt <= bit_cnt+1.
  - On the rise that completes bit NBIT: oRXdata <= the shifted value, pulse oRXvalid, move to DONE.
  - Synchronized SS high before NBIT rises: pulse oFRAMEerr, leave oRXdata unchanged, move to IDLE.
- DONE:
  - oMISO=1; further SCLK edges are ignored.
  - Synchronized SS high: move to IDLE. No error is flagged in this case.
- Width rule: bit_cnt is $clog2(NBIT+1) bits wide and never exceeds NBIT.
- Boundary conditions:
  - The Nth rise and SS deassert detected in the same cycle count as a complete frame: oRXvalid pulses and oFRAMEerr does not.
  - A sclk_rise and sclk_fall cannot be detected in the same cycle, by construction.
  - An ss_fall seen while in SHIFT or DONE is impossible, because SS must rise first.
  - iTXdata changes during a frame are ignored.
  - Reset mid-frame returns the block to IDLE with all outputs at reset values.
  - After any reset, a frame starts only on an ss_fall that follows an observed high on synchronized SS. To guarantee this, the SS synchronizer and its edge register reset to 0, so a frame already in progress at reset is never joined.

## Timing
- Reset values:
  - oMISO=1, oRXdata=0, oRXvalid=0, oFRAMEerr=0, oBUSY=0.
  - Internal: tx_sr=0, rx_sr=0, bit_cnt=0.
  - Synchronizers: SCLK chain reset to 1; SS chain reset to 0.
- Pin edge to detected strobe: SYNC_STAGES+1 cycles.
- oMISO changes 1 cycle after the sclk_fall strobe, i.e. SYNC_STAGES+2 cycles after the pin edge.
- oRXvalid asserts 1 cycle after the Nth sclk_rise strobe.
- Constraint: each SCLK half-period must exceed SYNC_STAGES+3 iCLK cycles. With equal clocks and SYNC_STAGES=2, the master's CLK_DIV must be at least 6.

## Structure
- Package spi_pkg holds:
  - state encoding ST_IDLE/ST_SHIFT/ST_DONE;
  - constants SPI_CPOL=1 and SPI_FILL_BIT=1'b1;
  - SYNC_STAGES_DEFAULT.
- Sub-module spi_sync_edge: parameterized synchronizer with a reset value plus rise/fall strobes. It is instantiated for iSCLK and iSS.
- iMOSI uses the same synchronizer without edge outputs, so data and clock stay aligned.

## Test plan
- NBIT=8, SYNC_STAGES=2, master-model half-period 8 cycles:
  - Full frame: iTXdata=8'hA5, master sends 8'h3C -> oRXdata=8'h3C, a single oRXvalid pulse, and the master sees 8'hA5 on MISO.
  - Back-to-back frames: 8'hFF then 8'h00, with iTXdata changing mid-frame -> two valid pulses. MISO returns the values captured at each ss_fall.
  - Abort: SS rises after 5 bits -> one oFRAMEerr pulse, oRXdata keeps its previous value, no oRXvalid.
  - Over-clocking: 10 SCLK periods within one SS-low window -> oRXdata = first 8 bits, one valid pulse, MISO=1 for the extra bits.
- Reset cases:
  - Assert iRST for 1 cycle during bit 3 of a frame -> outputs reset and the rest of the frame is ignored.
  - Then release with SS held low from before reset through the release -> no oBUSY until SS rises and falls again.
- NBIT=128: 128'h0123…CDEF exchanged both directions with CLK_DIV=6 -> bit-exact, oRXvalid asserts 1 cycle after the 128th rise strobe.
